// File: rtl/fp_cordic_pkg.sv
// Shared definitions for the HCORDIC floating-point descale path:
// default field widths, idle-select encodings and operand field slicers.
package fp_cordic_pkg;

   localparam int EXP_W_DEF = 8;
   localparam int MAN_W_DEF = 24;
   localparam int BIAS_DEF  = 127;

   // Widest operand / field the slicers handle; callers cast down to their widths.
   localparam int OP_MAX  = 64;
   localparam int EXP_MAX = 16;
   localparam int MAN_MAX = 32;

   localparam logic NO_IDLE  = 1'b0;
   localparam logic PUT_IDLE = 1'b1;

   // Operand layout is {sign, exp[exp_w-1:0], man[man_w-1:0]}.
   function automatic logic sign_of(input logic [OP_MAX-1:0] op,
                                    input int exp_w, input int man_w);
      return 1'(op >> (exp_w + man_w));
   endfunction

   function automatic logic [EXP_MAX-1:0] exp_of(input logic [OP_MAX-1:0] op,
                                                 input int exp_w, input int man_w);
      return EXP_MAX'((op >> man_w) & ((OP_MAX'(1) << exp_w) - OP_MAX'(1)));
   endfunction

   function automatic logic [MAN_MAX-1:0] man_of(input logic [OP_MAX-1:0] op,
                                                 input int man_w);
      return MAN_MAX'(op & ((OP_MAX'(1) << man_w) - OP_MAX'(1)));
   endfunction

endpackage

// File: rtl/fp_mult_descale_pipe_if.sv
// Input/output beat bundle of the descale multiply stage. The stage itself
// uses the slave view; whoever feeds and drains it uses the master view.
interface fp_mult_descale_pipe_if import fp_cordic_pkg::*; #(
   parameter int EXP_W = EXP_W_DEF,
   parameter int MAN_W = MAN_W_DEF,
   parameter int TAG_W = 8,
   parameter int Z_W   = 32
);
   localparam int OP_W = 1 + EXP_W + MAN_W;
   localparam int PR_W = 2 * MAN_W + 2;

   logic             in_valid;
   logic             in_ready;
   logic [OP_W-1:0]  in_aout;
   logic [OP_W-1:0]  in_bout;
   logic [OP_W-1:0]  in_zout;
   logic             in_idle;
   logic [TAG_W-1:0] in_tag;
   logic             in_scale_valid;
   logic [Z_W-1:0]   in_z;

   logic             out_valid;
   logic             out_ready;
   logic             out_idle;
   logic [OP_W-1:0]  out_zout;
   logic [PR_W-1:0]  out_product;
   logic [TAG_W-1:0] out_tag;
   logic             out_scale_valid;
   logic [Z_W-1:0]   out_z;
   logic             out_exp_ovf;
   logic             out_exp_unf;

   modport master (
      output in_valid, in_aout, in_bout, in_zout, in_idle, in_tag,
             in_scale_valid, in_z, out_ready,
      input  in_ready, out_valid, out_idle, out_zout, out_product, out_tag,
             out_scale_valid, out_z, out_exp_ovf, out_exp_unf
   );

   modport slave (
      input  in_valid, in_aout, in_bout, in_zout, in_idle, in_tag,
             in_scale_valid, in_z, out_ready,
      output in_ready, out_valid, out_idle, out_zout, out_product, out_tag,
             out_scale_valid, out_z, out_exp_ovf, out_exp_unf
   );

endinterface

// File: rtl/mult_pipe.sv
// Unsigned MAN_W x MAN_W mantissa multiplier, registered STAGES deep.
// All stages advance together on en and hold otherwise.
module mult_pipe #(
   parameter int MAN_W  = 24,
   parameter int STAGES = 2
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               en,
   input  logic [MAN_W-1:0]   a,
   input  logic [MAN_W-1:0]   b,
   output logic [2*MAN_W-1:0] p
);
   localparam int PW = 2 * MAN_W;

   logic [STAGES-1:0][PW-1:0] prod_q;
   logic [STAGES-1:0][PW-1:0] prod_d;

   // Multiply into the first stage and shift the rest when enabled.
   always_comb begin
      prod_d = prod_q;
      if (en) begin
         prod_d[0] = PW'(a) * PW'(b);
         for (int i = 1; i < STAGES; i++) begin
            prod_d[i] = prod_q[i-1];
         end
      end
   end

   // Product pipeline registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prod_q <= '0;
      end else begin
         prod_q <= prod_d;
      end
   end

   assign p = prod_q[STAGES-1];

endmodule

// File: rtl/fp_mult_descale_pipe.sv
// Multiply stage of the HCORDIC descale path: product sign, unbiased
// exponent sum with range flags, and full mantissa product. Sign/exponent/
// flag/sideband words travel in a shift register that moves in lock-step
// with the multiplier pipeline, so latency is exactly STAGES cycles.
module fp_mult_descale_pipe import fp_cordic_pkg::*; #(
   parameter int EXP_W  = EXP_W_DEF,
   parameter int MAN_W  = MAN_W_DEF,
   parameter int BIAS   = BIAS_DEF,
   parameter int TAG_W  = 8,
   parameter int Z_W    = 32,
   parameter int STAGES = 2
) (
   input logic                  clock,
   input logic                  reset,
   fp_mult_descale_pipe_if.slave bus
);
   localparam int OP_W = 1 + EXP_W + MAN_W;
   localparam int EW2  = EXP_W + 2;

   typedef struct packed {
      logic             valid;
      logic             idle;
      logic [OP_W-1:0]  zout;
      logic             ovf;
      logic             unf;
      logic [TAG_W-1:0] tag;
      logic             scale_valid;
      logic [Z_W-1:0]   z;
   } stage_t;

   stage_t [STAGES-1:0] stage_q;
   stage_t [STAGES-1:0] stage_d;
   stage_t              entry;

   logic                  en;
   logic                  a_sign;
   logic                  b_sign;
   logic [EXP_W-1:0]      a_exp;
   logic [EXP_W-1:0]      b_exp;
   logic [MAN_W-1:0]      a_man;
   logic [MAN_W-1:0]      b_man;
   logic [MAN_W-1:0]      mul_a;
   logic [MAN_W-1:0]      mul_b;
   logic signed [EW2-1:0] ea;
   logic signed [EW2-1:0] eb;
   logic signed [EW2-1:0] exp_sum;
   logic [2*MAN_W-1:0]    mant_prod;

   // The whole stage moves only when the output slot is free or being drained.
   assign en           = !stage_q[STAGES-1].valid || bus.out_ready;
   assign bus.in_ready = en;

   // Decode the incoming beat into the word that enters the first stage.
   // Idle beats feed zeros to the multiplier so their product comes out 0.
   always_comb begin
      a_sign  = sign_of(OP_MAX'(bus.in_aout), EXP_W, MAN_W);
      b_sign  = sign_of(OP_MAX'(bus.in_bout), EXP_W, MAN_W);
      a_exp   = EXP_W'(exp_of(OP_MAX'(bus.in_aout), EXP_W, MAN_W));
      b_exp   = EXP_W'(exp_of(OP_MAX'(bus.in_bout), EXP_W, MAN_W));
      a_man   = MAN_W'(man_of(OP_MAX'(bus.in_aout), MAN_W));
      b_man   = MAN_W'(man_of(OP_MAX'(bus.in_bout), MAN_W));
      ea      = $signed({2'b00, a_exp}) - $signed(EW2'(BIAS));
      eb      = $signed({2'b00, b_exp}) - $signed(EW2'(BIAS));
      exp_sum = ea + eb + $signed(EW2'(1));

      entry             = '0;
      entry.valid       = bus.in_valid;
      entry.idle        = bus.in_idle;
      entry.tag         = bus.in_tag;
      entry.scale_valid = bus.in_scale_valid;
      entry.z           = bus.in_z;
      mul_a             = '0;
      mul_b             = '0;
      if (bus.in_idle == PUT_IDLE) begin
         entry.zout = bus.in_zout;
      end else begin
         // Exponent field keeps only the low EXP_W bits; out-of-range sums wrap.
         entry.zout = {a_sign ^ b_sign, exp_sum[EXP_W-1:0], {MAN_W{1'b0}}};
         entry.ovf  = exp_sum > $signed(EW2'(BIAS));
         entry.unf  = exp_sum < $signed(EW2'(1 - BIAS));
         mul_a      = a_man;
         mul_b      = b_man;
      end
   end

   // Shift the side pipeline when enabled; a missing input beat becomes a bubble.
   always_comb begin
      stage_d = stage_q;
      if (en) begin
         stage_d[0] = entry;
         for (int i = 1; i < STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
         end
      end
   end

   // Side pipeline registers; reset drops any beat in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   mult_pipe #(
      .MAN_W  (MAN_W),
      .STAGES (STAGES)
   ) u_mult_pipe (
      .clock (clock),
      .reset (reset),
      .en    (en),
      .a     (mul_a),
      .b     (mul_b),
      .p     (mant_prod)
   );

   assign bus.out_valid       = stage_q[STAGES-1].valid;
   assign bus.out_idle        = stage_q[STAGES-1].idle;
   assign bus.out_zout        = stage_q[STAGES-1].zout;
   assign bus.out_product     = {mant_prod, 2'b00};
   assign bus.out_tag         = stage_q[STAGES-1].tag;
   assign bus.out_scale_valid = stage_q[STAGES-1].scale_valid;
   assign bus.out_z           = stage_q[STAGES-1].z;
   assign bus.out_exp_ovf     = stage_q[STAGES-1].ovf;
   assign bus.out_exp_unf     = stage_q[STAGES-1].unf;

endmodule

// File: tb/tb_fp_mult_descale_pipe.sv
// Bench for fp_mult_descale_pipe at default widths, STAGES=2.
module tb_fp_mult_descale_pipe;

   localparam int EXP_W  = 8;
   localparam int MAN_W  = 24;
   localparam int TAG_W  = 8;
   localparam int Z_W    = 32;
   localparam int STAGES = 2;

   logic clock = 1'b0;
   logic reset = 1'b1;

   fp_mult_descale_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W), .Z_W(Z_W)) bus();

   fp_mult_descale_pipe #(
      .EXP_W(EXP_W), .MAN_W(MAN_W), .BIAS(127), .TAG_W(TAG_W), .Z_W(Z_W), .STAGES(STAGES)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        idle;
      logic [32:0] zout;
      logic [49:0] product;
      logic [7:0]  tag;
      logic        sv;
      logic [31:0] z;
      logic        ovf;
      logic        unf;
      int          acc;
   } exp_t;

   exp_t        q[$];
   exp_t        man_exp;
   bit          use_man = 0;
   bit          chk_lat = 0;
   bit          acc_last = 0;
   int          n_checks = 0;
   int          n_pass = 0;
   int          cyc = 0;
   int          n_emit = 0;
   bit          hold_v = 0;
   logic [32:0] hold_zout;
   logic [49:0] hold_prod;
   logic [7:0]  hold_tag;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      if (obs === expv) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
   endtask

   // Reference: plain integer arithmetic on the operand fields.
   function automatic exp_t model(input logic [32:0] a, input logic [32:0] b,
                                  input logic [32:0] zin, input logic idle,
                                  input logic [7:0] tag, input logic sv,
                                  input logic [31:0] z);
      exp_t        e;
      int          s;
      logic [63:0] p;
      e.idle = idle; e.tag = tag; e.sv = sv; e.z = z; e.acc = 0;
      if (idle) begin
         e.zout = zin; e.product = '0; e.ovf = 1'b0; e.unf = 1'b0;
      end else begin
         s = (int'(a[31:24]) - 127) + (int'(b[31:24]) - 127) + 1;
         p = 64'(a[23:0]) * 64'(b[23:0]) * 64'd4;
         e.zout    = {a[32] ^ b[32], 8'(s), 24'h0};
         e.product = 50'(p);
         e.ovf     = (s > 127);
         e.unf     = (s < -126);
      end
      return e;
   endfunction

   task automatic set_in(input logic [32:0] a, input logic [32:0] b, input logic [32:0] zin,
                         input logic idle, input logic [7:0] tag);
      bus.in_aout        = a;
      bus.in_bout        = b;
      bus.in_zout        = zin;
      bus.in_idle        = idle;
      bus.in_tag         = tag;
      bus.in_scale_valid = tag[0];
      bus.in_z           = {4{tag}};
   endtask

   // Called at a falling edge with inputs already driven; samples, scores, advances.
   task automatic step_cycle();
      exp_t e;
      #1;
      check_val("in_ready", 64'(bus.in_ready), 64'(!bus.out_valid || bus.out_ready));
      if (hold_v) begin
         check_val("hold_valid", 64'(bus.out_valid), 64'd1);
         check_val("hold_zout", 64'(bus.out_zout), 64'(hold_zout));
         check_val("hold_prod", 64'(bus.out_product), 64'(hold_prod));
         check_val("hold_tag", 64'(bus.out_tag), 64'(hold_tag));
      end
      if (bus.out_valid && bus.out_ready) begin
         n_emit++;
         if (q.size() == 0) begin
            check_val("out_when_empty", 64'(bus.out_valid), 64'd0);
         end else begin
            e = q.pop_front();
            check_val("zout", 64'(bus.out_zout), 64'(e.zout));
            check_val("product", 64'(bus.out_product), 64'(e.product));
            check_val("tag", 64'(bus.out_tag), 64'(e.tag));
            check_val("idle", 64'(bus.out_idle), 64'(e.idle));
            check_val("scale_valid", 64'(bus.out_scale_valid), 64'(e.sv));
            check_val("z", 64'(bus.out_z), 64'(e.z));
            check_val("ovf", 64'(bus.out_exp_ovf), 64'(e.ovf));
            check_val("unf", 64'(bus.out_exp_unf), 64'(e.unf));
            if (chk_lat) check_val("latency", 64'(cyc - e.acc), 64'(STAGES));
         end
      end
      hold_v    = bus.out_valid && !bus.out_ready;
      hold_zout = bus.out_zout;
      hold_prod = bus.out_product;
      hold_tag  = bus.out_tag;
      acc_last  = bus.in_valid && bus.in_ready;
      if (acc_last) begin
         if (use_man) e = man_exp;
         else e = model(bus.in_aout, bus.in_bout, bus.in_zout, bus.in_idle,
                        bus.in_tag, bus.in_scale_valid, bus.in_z);
         e.acc = cyc;
         q.push_back(e);
      end
      @(negedge clock);
      cyc++;
   endtask

   task automatic dir_beat(input logic [32:0] a, input logic [32:0] b, input logic [32:0] zin,
                           input logic idle, input logic [7:0] tag,
                           input logic [32:0] zout_e, input logic [49:0] prod_e,
                           input logic ovf_e, input logic unf_e);
      set_in(a, b, zin, idle, tag);
      bus.in_valid    = 1'b1;
      man_exp.idle    = idle;
      man_exp.zout    = zout_e;
      man_exp.product = prod_e;
      man_exp.tag     = tag;
      man_exp.sv      = tag[0];
      man_exp.z       = {4{tag}};
      man_exp.ovf     = ovf_e;
      man_exp.unf     = unf_e;
      man_exp.acc     = 0;
      step_cycle();
   endtask

   task automatic drain(input string tag);
      int budget;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      budget = 0;
      while (q.size() > 0 && budget < 30) begin
         step_cycle();
         budget++;
      end
      check_val(tag, 64'(q.size()), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int kk, cl, e0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      set_in('0, '0, '0, 1'b0, 8'h00);

      repeat (2) @(negedge clock);
      #1;
      check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check_val("rst_zout", 64'(bus.out_zout), 64'd0);
      check_val("rst_product", 64'(bus.out_product), 64'd0);
      check_val("rst_tag", 64'(bus.out_tag), 64'd0);
      check_val("rst_flags", 64'({bus.out_exp_ovf, bus.out_exp_unf}), 64'd0);
      check_val("rst_in_ready", 64'(bus.in_ready), 64'd1);
      reset = 1'b0;
      @(negedge clock);

      // Directed vectors, back to back at full throughput.
      bus.out_ready = 1'b1;
      chk_lat = 1; use_man = 1;
      dir_beat(33'h0_7F80_0000, 33'h0_7F80_0000, '0, 1'b0, 8'h5A,
               33'h0_0100_0000, 50'h1000000000000, 1'b0, 1'b0);
      dir_beat(33'h1_8080_0000, 33'h0_7FC0_0000, '0, 1'b0, 8'h02,
               33'h1_0200_0000, 50'h1800000000000, 1'b0, 1'b0);
      dir_beat(33'h0_FE80_0000, 33'h0_FE80_0000, '0, 1'b0, 8'h03,
               33'h0_FF00_0000, 50'h1000000000000, 1'b1, 1'b0);
      dir_beat(33'h0_0180_0000, 33'h0_0180_0000, '0, 1'b0, 8'h04,
               33'h0_0500_0000, 50'h1000000000000, 1'b0, 1'b1);
      dir_beat(33'h0_7FFF_FFFF, 33'h1_7FFF_FFFF, 33'h1_7FC0_0000, 1'b1, 8'h05,
               33'h1_7FC0_0000, 50'h0, 1'b0, 1'b0);
      use_man = 0;
      drain("dir_drain");
      chk_lat = 0;

      // Six beats with a four-cycle downstream stall in the middle.
      e0 = n_emit;
      kk = 1; cl = 0;
      while (kk <= 6 && cl < 40) begin
         bus.out_ready = !(cl >= 3 && cl < 7);
         bus.in_valid  = 1'b1;
         set_in({kk[0], 8'(120 + kk), 24'h800000 | 24'(kk)},
                {1'b0, 8'(130 - kk), 24'hA00000 + 24'(kk)}, '0, 1'b0, 8'(kk));
         if (cl == 5) begin
            #1;
            check_val("stall_in_ready", 64'(bus.in_ready), 64'd0);
         end
         step_cycle();
         if (acc_last) kk++;
         cl++;
      end
      check_val("bp_all_sent", 64'(kk), 64'd7);
      drain("bp_drain");
      check_val("bp_emitted", 64'(n_emit - e0), 64'd6);

      // Random traffic with random backpressure and idle beats.
      for (int i = 0; i < 400; i++) begin
         bus.in_valid  = ($urandom_range(0, 9) < 7);
         bus.out_ready = ($urandom_range(0, 9) < 7);
         set_in({1'($urandom), 8'($urandom), 24'($urandom)},
                {1'($urandom), 8'($urandom), 24'($urandom)},
                {1'($urandom), 32'($urandom)},
                ($urandom_range(0, 9) == 0), 8'($urandom));
         step_cycle();
      end
      drain("rand_drain");

      // Reset with two beats inside the pipeline.
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      set_in(33'h0_8012_3456, 33'h1_7A65_4321, '0, 1'b0, 8'hA1);
      step_cycle();
      set_in(33'h1_9000_0001, 33'h0_6FFF_FFFF, '0, 1'b0, 8'hA2);
      step_cycle();
      bus.in_valid = 1'b0;
      check_val("pre_rst_inflight", 64'(bus.out_valid), 64'd1);
      reset = 1'b1;
      #1;
      check_val("rst_mid_valid", 64'(bus.out_valid), 64'd0);
      check_val("rst_mid_product", 64'(bus.out_product), 64'd0);
      check_val("rst_mid_tag", 64'(bus.out_tag), 64'd0);
      q.delete();
      hold_v = 0;
      @(negedge clock);
      reset = 1'b0;
      e0 = n_emit;
      repeat (6) step_cycle();
      check_val("post_rst_emitted", 64'(n_emit - e0), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
